axi_ram_sp_arb: RTL and testbench

AXI_RAM_SP_ARB -- requirements
Module: axi_ram_sp_arb

---
 rtl/axi_ram_pkg.sv | 36 +++
 rtl/axi_burst_addr.sv | 28 ++
 rtl/axi_ram_sp_arb.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_ram_sp_arb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_pkg.sv
// Shared encodings for the single-port AXI RAM: burst types, response codes,
// channel FSM states and port-ownership tags.
package axi_ram_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_BURST,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_WRITE,
    OWN_READ
  } owner_e;

  // Only these burst lengths form a legal wrapping window; anything else steps as INCR.
  function automatic logic is_wrap_len(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next word index of an AXI burst, for FIXED, INCR and WRAP stepping.
module axi_burst_addr
  import axi_ram_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [1:0]       burst,
  input  logic [7:0]       len,
  output logic [IDX_W-1:0] next_idx
);

  logic [IDX_W-1:0] inc;
  logic [IDX_W-1:0] mask;

  // FIXED holds, legal WRAP stays inside the aligned window, everything else increments.
  always_comb begin
    inc      = idx + IDX_W'(1);
    mask     = IDX_W'(len[3:0]);
    next_idx = inc;
    if (burst == BURST_FIXED) begin
      next_idx = idx;
    end else if ((burst == BURST_WRAP) && is_wrap_len(len)) begin
      next_idx = (idx & ~mask) | (inc & mask);
    end
  end

endmodule

// File: rtl/axi_ram_sp_arb.sv
// AXI4 slave RAM on a single-port array. Write and read bursts arbitrate for
// the port one whole burst at a time; the read side has a 1-entry output register.
module axi_ram_sp_arb
  import axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SIZE_FULL  = $clog2(STRB_WIDTH);
  localparam int IDX_W      = ADDR_WIDTH - SIZE_FULL;
  localparam int DEPTH      = 2 ** IDX_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_e w_state, w_next;
  r_state_e r_state, r_next;
  owner_e   owner;
  logic     prio_w;

  // Write burst context
  logic [IDX_W-1:0]    w_idx, w_idx_nxt;
  logic [1:0]          w_burst;
  logic [7:0]          w_len, w_cnt;
  logic [ID_WIDTH-1:0] w_id;
  logic                w_err;

  // Read burst context
  logic [IDX_W-1:0]    r_idx, r_idx_nxt;
  logic [1:0]          r_burst;
  logic [7:0]          r_len, r_cnt;
  logic [ID_WIDTH-1:0] r_id;
  logic                r_err;

  // Read output register
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] rdata_p1;
  logic [ID_WIDTH-1:0]   rid_p1;
  logic [1:0]            rresp_p1;
  logic                  rlast_p1;

  logic aw_elig, ar_elig, grant_w, grant_r;
  logic w_hs, w_final, r_drain, rd_acc, r_final, mem_we;
  logic [IDX_W-1:0] port_idx;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot,
                           s_axi_awaddr[SIZE_FULL-1:0], s_axi_araddr[SIZE_FULL-1:0]};

  // Burst-level arbitration: only a free port can be granted, ties go to prio_w
  always_comb begin
    aw_elig = s_axi_awvalid && (w_state == W_IDLE) && (owner == OWN_NONE) && !rst;
    ar_elig = s_axi_arvalid && (r_state == R_IDLE) && (owner == OWN_NONE) && !rst;
    grant_w = aw_elig && (!ar_elig || prio_w);
    grant_r = ar_elig && (!aw_elig || !prio_w);
  end

  assign s_axi_awready = grant_w;
  assign s_axi_arready = grant_r;
  assign s_axi_wready  = (w_state == W_BURST) && (owner == OWN_WRITE) && !rst;
  assign s_axi_bvalid  = (w_state == W_RESP) && !rst;
  assign s_axi_bid     = w_id;
  assign s_axi_bresp   = w_err ? RESP_SLVERR : RESP_OKAY;

  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign w_final = (w_cnt == w_len);
  assign mem_we  = w_hs && !w_err;

  // A read access needs the output register empty or draining this cycle
  assign r_drain  = s_axi_rvalid && s_axi_rready;
  assign rd_acc   = (owner == OWN_READ) && (!vld_p1 || r_drain) && !rst;
  assign r_final  = (r_cnt == r_len);
  assign port_idx = (owner == OWN_WRITE) ? w_idx : r_idx;

  axi_burst_addr #(.IDX_W(IDX_W)) u_w_addr (
    .idx      (w_idx),
    .burst    (w_burst),
    .len      (w_len),
    .next_idx (w_idx_nxt)
  );

  axi_burst_addr #(.IDX_W(IDX_W)) u_r_addr (
    .idx      (r_idx),
    .burst    (r_burst),
    .len      (r_len),
    .next_idx (r_idx_nxt)
  );

  // Write FSM next state
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (grant_w)           w_next = W_BURST;
      W_BURST: if (w_hs && w_final)   w_next = W_RESP;
      W_RESP:  if (s_axi_bready)      w_next = W_IDLE;
      default:                        w_next = W_IDLE;
    endcase
  end

  // Read FSM next state: the burst ends when its last beat leaves the output register
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (grant_r)                 r_next = R_BURST;
      R_BURST: if (r_drain && s_axi_rlast)  r_next = R_IDLE;
      default:                              r_next = R_IDLE;
    endcase
  end

  // FSM state, port owner and tie priority
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      owner   <= OWN_NONE;
      prio_w  <= 1'b1;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (grant_w) begin
        owner  <= OWN_WRITE;
        prio_w <= 1'b0;
      end else if (grant_r) begin
        owner  <= OWN_READ;
        prio_w <= 1'b1;
      end else if ((owner == OWN_WRITE) && w_hs && w_final) begin
        owner  <= OWN_NONE;
      end else if (rd_acc && r_final) begin
        owner  <= OWN_NONE;
      end
    end
  end

  // Burst context capture and stepping
  always_ff @(posedge clk) begin
    if (grant_w) begin
      w_idx   <= s_axi_awaddr[ADDR_WIDTH-1:SIZE_FULL];
      w_burst <= s_axi_awburst;
      w_len   <= s_axi_awlen;
      w_cnt   <= 8'd0;
    end else if (w_hs) begin
      w_idx   <= w_idx_nxt;
      w_cnt   <= w_cnt + 8'd1;
    end
    if (grant_r) begin
      r_idx   <= s_axi_araddr[ADDR_WIDTH-1:SIZE_FULL];
      r_burst <= s_axi_arburst;
      r_len   <= s_axi_arlen;
      r_cnt   <= 8'd0;
      r_id    <= s_axi_arid;
      r_err   <= (s_axi_arsize != 3'(SIZE_FULL));
    end else if (rd_acc) begin
      r_idx   <= r_idx_nxt;
      r_cnt   <= r_cnt + 8'd1;
    end
  end

  // Write response ID/error flag, visible on B
  always_ff @(posedge clk) begin
    if (rst) begin
      w_id  <= '0;
      w_err <= 1'b0;
    end else if (grant_w) begin
      w_id  <= s_axi_awid;
      w_err <= (s_axi_awsize != 3'(SIZE_FULL));
    end
  end

  // Single-port array: one byte-masked write or one word read per cycle
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem[port_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
    if (rd_acc) rdata_p1 <= mem[port_idx];
  end

  // ---- stage p1: read output register, held until rready ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      rid_p1   <= '0;
      rresp_p1 <= RESP_OKAY;
      rlast_p1 <= 1'b0;
    end else if (rd_acc) begin
      vld_p1   <= 1'b1;
      rid_p1   <= r_id;
      rresp_p1 <= r_err ? RESP_SLVERR : RESP_OKAY;
      rlast_p1 <= r_final;
    end else if (r_drain) begin
      vld_p1   <= 1'b0;
    end
  end

  assign s_axi_rvalid = vld_p1 && !rst;
  assign s_axi_rid    = rid_p1;
  assign s_axi_rresp  = rresp_p1;
  assign s_axi_rlast  = rlast_p1;
  assign s_axi_rdata  = (rresp_p1 == RESP_SLVERR) ? '0 : rdata_p1;

endmodule

// File: tb/tb_axi_ram_sp_arb.sv
// Directed bench for axi_ram_sp_arb at default parameters (1024 x 512-bit words).
module tb_axi_ram_sp_arb;

  localparam int DW = 512;
  localparam int AW = 16;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] awid = '0;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [IW-1:0] arid = '0;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic [2:0]    arsize = '0;
  logic [1:0]    arburst = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int aw_hs_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (awvalid && awready) aw_hs_cnt <= aw_hs_cnt + 1;

  axi_ram_sp_arb dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!awready && t < 60) begin @(negedge clk); t++; end
    chk("aw_handshake", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arready && t < 60) begin @(negedge clk); t++; end
    chk("ar_handshake", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
    int t;
    wdata = d; wstrb = s; wvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!wready && t < 60) begin @(negedge clk); t++; end
    chk("w_handshake", wready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic do_b(input logic [IW-1:0] eid, input logic [1:0] eresp);
    int t;
    bready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bvalid && t < 60) begin @(negedge clk); t++; end
    chk("bvalid", bvalid, 1);
    chk("bid", bid, eid);
    chk("bresp", bresp, eresp);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_r(input logic [DW-1:0] ed, input logic el, input logic [1:0] eresp,
                      input logic [IW-1:0] eid);
    int t;
    rready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rvalid && t < 60) begin @(negedge clk); t++; end
    chk("rvalid", rvalid, 1);
    chk("rdata", rdata, ed);
    chk("rlast", rlast, el);
    chk("rresp", rresp, eresp);
    chk("rid", rid, eid);
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    int old_cnt;
    int t;

    // Reset with AW and AR already pending: nothing may be ready during reset
    awid = 4'd5; awaddr = 16'h0040; awlen = 8'd3; awsize = 3'd6; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'd6; araddr = 16'h0040; arlen = 8'd3; arsize = 3'd6; arburst = 2'b01; arvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bid_bresp", {bid, bresp}, 0);
    chk("rst_rid_rresp_rlast", {rid, rresp, rlast}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First tie after reset goes to write; read waits for the whole write burst
    @(negedge clk);
    chk("tie1_awready", awready, 1);
    chk("tie1_arready", arready, 0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("ar_blocked_during_write", arready, 0);
      do_w(DW'(i), '1);
    end
    do_ar(4'd6, 16'h0040, 8'd3, 3'd6, 2'b01);
    do_b(4'd5, 2'b00);
    do_r(DW'(1), 1'b0, 2'b00, 4'd6);
    do_r(DW'(2), 1'b0, 2'b00, 4'd6);
    do_r(DW'(3), 1'b0, 2'b00, 4'd6);
    do_r(DW'(4), 1'b1, 2'b00, 4'd6);

    // INCR write at the top word wraps to word 0
    do_aw(4'd1, 16'hFFC0, 8'd1, 3'd6, 2'b01);
    do_w(DW'(32'hA), '1);
    do_w(DW'(32'hB), '1);
    do_b(4'd1, 2'b00);

    // Tie after a write burst goes to read (WRAP read of word 3)
    awid = 4'd2; awaddr = 16'h0080; awlen = 8'd0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'd3; araddr = 16'h00C0; arlen = 8'd3; arsize = 3'd6; arburst = 2'b10; arvalid = 1'b1;
    old_cnt = aw_hs_cnt;
    @(negedge clk);
    chk("tie2_arready", arready, 1);
    chk("tie2_awready", awready, 0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    do_r(DW'(3), 1'b0, 2'b00, 4'd3);
    do_r(DW'(32'hB), 1'b0, 2'b00, 4'd3);
    do_r(DW'(1), 1'b0, 2'b00, 4'd3);
    do_r(DW'(2), 1'b1, 2'b00, 4'd3);

    // Pending narrow-size write is granted after the read: no bytes written, SLVERR
    t = 0;
    while (aw_hs_cnt == old_cnt && t < 60) begin @(posedge clk); #1; t++; end
    chk("narrow_aw_granted", aw_hs_cnt - old_cnt, 1);
    awvalid = 1'b0;
    do_w(DW'(32'hDEAD), '1);
    do_b(4'd2, 2'b10);
    do_ar(4'd4, 16'h0080, 8'd0, 3'd6, 2'b01);
    do_r(DW'(2), 1'b1, 2'b00, 4'd4);

    // Byte strobes, then FIXED read of word 5 three times
    do_aw(4'd7, 16'h0140, 8'd0, 3'd6, 2'b01);
    do_w(DW'(32'h11223344), '1);
    do_b(4'd7, 2'b00);
    do_aw(4'd7, 16'h0140, 8'd0, 3'd6, 2'b01);
    do_w(DW'(32'hAABBCCDD), SW'(1));
    do_b(4'd7, 2'b00);
    do_ar(4'd8, 16'h0140, 8'd2, 3'd6, 2'b00);
    do_r(DW'(32'h112233DD), 1'b0, 2'b00, 4'd8);
    do_r(DW'(32'h112233DD), 1'b0, 2'b00, 4'd8);
    do_r(DW'(32'h112233DD), 1'b1, 2'b00, 4'd8);

    // INCR read across the top of memory
    do_ar(4'd9, 16'hFFC0, 8'd1, 3'd6, 2'b01);
    do_r(DW'(32'hA), 1'b0, 2'b00, 4'd9);
    do_r(DW'(32'hB), 1'b1, 2'b00, 4'd9);

    // rready low for 5 cycles mid-burst: beat 3 held stable, nothing lost
    do_ar(4'd10, 16'h0040, 8'd3, 3'd6, 2'b01);
    do_r(DW'(1), 1'b0, 2'b00, 4'd10);
    do_r(DW'(2), 1'b0, 2'b00, 4'd10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rvalid", rvalid, 1);
      chk("stall_rdata", rdata, DW'(3));
    end
    @(posedge clk); #1;
    do_r(DW'(3), 1'b0, 2'b00, 4'd10);
    do_r(DW'(4), 1'b1, 2'b00, 4'd10);

    // Narrow-size read: zero data, SLVERR on every beat
    do_ar(4'd11, 16'h0040, 8'd1, 3'd5, 2'b01);
    do_r('0, 1'b0, 2'b10, 4'd11);
    do_r('0, 1'b1, 2'b10, 4'd11);

    // Reset during W_BURST aborts with no response; AW ready right after reset
    do_aw(4'd12, 16'h0280, 8'd3, 3'd6, 2'b01);
    do_w(DW'(32'h55), '1);
    rst = 1'b1;
    awid = 4'd13; awaddr = 16'h0280; awlen = 8'd0; awsize = 3'd6; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    chk("midrst_awready", awready, 0);
    chk("midrst_wready", wready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_awready", awready, 1);
    chk("postrst_bvalid", bvalid, 0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    do_w(DW'(32'h66), '1);
    do_b(4'd13, 2'b00);
    do_ar(4'd14, 16'h0280, 8'd0, 3'd6, 2'b01);
    do_r(DW'(32'h66), 1'b1, 2'b00, 4'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
